regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_busy.sv | 32 +++
 rtl/regfile_mp.sv | 51 +++++
 tb/tb_regfile_mp.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants, address-width helper and address type
package regfile_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int NREGS_DEFAULT = 32;
  function automatic int addr_width(input int nregs);
    return $clog2(nregs);
  endfunction
  typedef logic [addr_width(NREGS_DEFAULT)-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_busy.sv
// regfile_busy: per-register pending-write scoreboard with flush, issue and writeback updates
module regfile_busy
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW = addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en_i,
  input  logic [AW-1:0]    write_addr_i,
  input  logic             issue_en_i,
  input  logic [AW-1:0]    issue_addr_i,
  input  logic             flush_i,
  output logic [NREGS-1:0] busy_vec_o
);
  logic [NREGS-1:0] busy_q, busy_d;
  // an issue always wins (it survives a flush and beats a same-cycle write); x0 is never busy
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++)
      busy_d[r] = (issue_en_i && issue_addr_i == AW'(r)) ? 1'b1 :
                  flush_i ? 1'b0 :
                  (write_en_i && write_addr_i == AW'(r)) ? 1'b0 : busy_q[r];
    busy_d[0] = 1'b0;
  end
  // busy vector register
  always_ff @(posedge clk or posedge rst)
    if (rst) busy_q <= '0;
    else busy_q <= busy_d;
  assign busy_vec_o = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-through bypass and busy scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NREAD = 2,
  parameter int AW = addr_width(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [AW-1:0]         write_addr,
  input  logic [XLEN-1:0]       write_data,
  input  logic                  issue_en,
  input  logic [AW-1:0]         issue_addr,
  input  logic                  flush,
  input  logic [NREAD*AW-1:0]   read_addr,
  output logic [NREAD*XLEN-1:0] read_data,
  output logic [NREAD-1:0]      read_busy
);
  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_vec;

  regfile_busy #(.NREGS(NREGS), .AW(AW)) u_busy (
    .clk          (clk),
    .rst          (rst),
    .write_en_i   (write_en),
    .write_addr_i (write_addr),
    .issue_en_i   (issue_en),
    .issue_addr_i (issue_addr),
    .flush_i      (flush),
    .busy_vec_o   (busy_vec)
  );

  // data array; x0 is never written so it stays at its reset value
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    else if (write_en && write_addr != '0) regs_q[write_addr] <= write_data;

  // reset also masks the bypass so every port reads zero while rst is held
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic zero, hit;
    assign a = read_addr[k*AW +: AW];
    assign zero = rst || a == '0;
    assign hit = write_en && write_addr == a;
    assign read_data[k*XLEN +: XLEN] = zero ? '0 : hit ? write_data : regs_q[a];
    assign read_busy[k] = !zero && busy_vec[a] && !hit;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: vector table, corner sequences and randomized checks against a reference model
module tb_regfile_mp;
  logic clk = 1'b0, rst = 1'b1;
  logic we = 1'b0, ie = 1'b0, fl = 1'b0;
  logic [4:0] wa = '0, ia = '0;
  logic [31:0] wd = '0;
  logic [9:0] ra = '0;
  logic [63:0] rd;
  logic [1:0] rb;
  logic p_we = 1'b0;
  logic [3:0] p_wa = '0;
  logic [63:0] p_wd = '0;
  logic [11:0] p_ra = '0;
  logic [191:0] p_rd;
  logic [2:0] p_rb;
  int errors = 0, checks = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .rst(rst), .write_en(we), .write_addr(wa), .write_data(wd),
    .issue_en(ie), .issue_addr(ia), .flush(fl), .read_addr(ra),
    .read_data(rd), .read_busy(rb)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NREAD(3)) dut_p (
    .clk(clk), .rst(rst), .write_en(p_we), .write_addr(p_wa), .write_data(p_wd),
    .issue_en(1'b0), .issue_addr(4'd0), .flush(1'b0), .read_addr(p_ra),
    .read_data(p_rd), .read_busy(p_rb)
  );

  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd;
    logic ie; logic [4:0] ia; logic fl;
    logic [4:0] r0, r1;
    logic [31:0] d0, d1; logic b0, b1;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic m_rb(input logic [4:0] a);
    return !rst && a != 5'd0 && m_busy[a] && !(we && wa == a);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  task automatic m_edge();
    logic [31:0] nb;
    nb = m_busy;
    for (int r = 1; r < 32; r++) begin
      if (fl) nb[r] = ie && ia == 5'(r);
      else if (ie && ia == 5'(r)) nb[r] = 1'b1;
      else if (we && wa == 5'(r)) nb[r] = 1'b0;
    end
    if (we && wa != 5'd0) m_regs[wa] = wd;
    m_busy = nb;
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s rd%0d x%0d", tag, k, ra[k*5 +: 5]), {32'd0, rd[k*32 +: 32]}, {32'd0, m_rd(ra[k*5 +: 5])});
      chk($sformatf("%s rb%0d x%0d", tag, k, ra[k*5 +: 5]), {63'd0, rb[k]}, {63'd0, m_rb(ra[k*5 +: 5])});
    end
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; ie = 1'b0; ia = '0; fl = 1'b0;
  endtask

  initial begin
    m_clear();
    tbl[0]  = '{1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7, 32'h0,        32'h12345678, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 1'b0, 5'd3, 5'd3, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd3, 5'd7, 32'h0,        32'h12345678, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd3, 5'd3, 32'h0,        32'h0,        1'b1, 1'b1};
    tbl[7]  = '{1'b1, 5'd3, 32'hA5,       1'b0, 5'd0, 1'b0, 5'd3, 5'd3, 32'hA5,       32'hA5,       1'b0, 1'b0};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd3, 5'd3, 32'hA5,       32'hA5,       1'b0, 1'b0};
    tbl[9]  = '{1'b1, 5'd9, 32'h55,       1'b1, 5'd9, 1'b0, 5'd9, 5'd3, 32'h55,       32'hA5,       1'b0, 1'b0};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd9, 5'd9, 32'h55,       32'h55,       1'b1, 1'b1};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b0, 5'd0, 5'd9, 32'h0,        32'h55,       1'b0, 1'b1};
    tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 5'd9, 32'h0,        32'h55,       1'b0, 1'b1};

    // reset state
    ra = {5'd7, 5'd1};
    #1;
    chk("reset rd", rd, 64'd0);
    chk("reset rb", {62'd0, rb}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // vector table
    for (int i = 0; i < 13; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      ie = tbl[i].ie; ia = tbl[i].ia; fl = tbl[i].fl;
      ra = {tbl[i].r1, tbl[i].r0};
      #1;
      chk($sformatf("vec%0d d0", i), {32'd0, rd[31:0]}, {32'd0, tbl[i].d0});
      chk($sformatf("vec%0d d1", i), {32'd0, rd[63:32]}, {32'd0, tbl[i].d1});
      chk($sformatf("vec%0d b0", i), {63'd0, rb[0]}, {63'd0, tbl[i].b0});
      chk($sformatf("vec%0d b1", i), {63'd0, rb[1]}, {63'd0, tbl[i].b1});
      tick();
    end

    // flush keeps only the register issued in the flush cycle
    idle();
    ie = 1'b1; ia = 5'd2; tick();
    ia = 5'd4; tick();
    ia = 5'd6; tick();
    idle();
    ra = {5'd6, 5'd2};
    #1;
    chk("preflush b x2", {63'd0, rb[0]}, 64'd1);
    chk("preflush b x6", {63'd0, rb[1]}, 64'd1);
    fl = 1'b1; ie = 1'b1; ia = 5'd4;
    tick();
    idle();
    ra = {5'd4, 5'd2};
    #1;
    chk("flush b x2", {63'd0, rb[0]}, 64'd0);
    chk("flush b x4", {63'd0, rb[1]}, 64'd1);
    ra = {5'd9, 5'd6};
    #1;
    chk("flush b x6", {63'd0, rb[0]}, 64'd0);
    chk("flush b x9", {63'd0, rb[1]}, 64'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 7));
      wd = $urandom;
      ie = 1'($urandom_range(0, 2) == 0);
      ia = 5'($urandom_range(0, 7));
      fl = 1'($urandom_range(0, 15) == 0);
      ra = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      check_all("rand");
      tick();
    end

    // asynchronous reset mid-cycle, including mid-write
    idle();
    ie = 1'b1; ia = 5'd4;
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    tick();
    idle();
    ra = {5'd4, 5'd5};
    #1;
    chk("pre-rst x5", {32'd0, rd[31:0]}, 64'hDEADBEEF);
    chk("pre-rst b x4", {63'd0, rb[1]}, 64'd1);
    we = 1'b1; wa = 5'd5; wd = 32'h13579BDF;
    #1;
    rst = 1'b1;
    #1;
    chk("rst x5", {32'd0, rd[31:0]}, 64'd0);
    chk("rst b x4", {63'd0, rb[1]}, 64'd0);
    m_clear();
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("post-rst x5", {32'd0, rd[31:0]}, 64'd0);
    check_all("post-rst");

    // 64-bit, 16-entry, 3-port instance
    for (int i = 1; i < 16; i++) begin
      p_we = 1'b1; p_wa = 4'(i);
      p_wd = (i == 15) ? 64'h0123456789ABCDEF : 64'h1111111111111111 * 64'(i);
      if (i == 15) begin
        p_ra = {4'd15, 4'd15, 4'd15};
        #1;
        chk("p bypass x15", p_rd[63:0], 64'h0123456789ABCDEF);
      end
      tick();
    end
    p_we = 1'b0;
    p_ra = {4'd15, 4'd15, 4'd15};
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("p rd%0d x15", k), p_rd[k*64 +: 64], 64'h0123456789ABCDEF);
    chk("p rb", {61'd0, p_rb}, 64'd0);
    p_ra = {4'd14, 4'd7, 4'd0};
    #1;
    chk("p x0", p_rd[63:0], 64'd0);
    chk("p x7", p_rd[127:64], 64'h7777777777777777);
    chk("p x14", p_rd[191:128], 64'hEEEEEEEEEEEEEEEE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
